// File: rtl/tdf_stream_queue.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tdf_stream_queue
//
// Elastic token queue placed in front of one input stream of a TDF operator
// datapath. It buffers {eos, data} tokens in a circular buffer and gives the
// operator FSM a valid/back-pressure handshake to fire on. All handshake
// outputs are decoded from registered state, so neither side of the
// handshake sees a combinational path through the queue.
//
// Parameters
//   WIDTH  data bits per token
//   DEPTH  token slots (power of two, >= 2)
//   AFULL  occupancy at or above which in_afull asserts (1..DEPTH)
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high; discards all queued tokens
//   in_d      in   producer token data
//   in_eos    in   producer token end-of-stream flag
//   in_v      in   producer token valid
//   in_b      out  back-pressure to producer (queue full)
//   in_afull  out  occupancy >= AFULL
//   out_d     out  head token data (0 while empty)
//   out_eos   out  head token EOS flag (0 while empty)
//   out_v     out  head token valid (queue non-empty)
//   out_b     in   back-pressure from consumer (head not taken)
//   level     out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module tdf_stream_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AFULL = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_d,
  input  logic                       in_eos,
  input  logic                       in_v,
  output logic                       in_b,
  output logic                       in_afull,
  output logic [WIDTH-1:0]           out_d,
  output logic                       out_eos,
  output logic                       out_v,
  input  logic                       out_b,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Stored token: MSB is the EOS flag, the rest is data.
  logic [WIDTH:0]     mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;

  logic               push;
  logic               pop;
  logic [WIDTH:0]     head;

  // ---------------------------------------------------------------------------
  // Handshake decode: registered state only.
  // ---------------------------------------------------------------------------
  assign out_v    = (level_q != '0);
  assign in_b     = (level_q == LVL_W'(DEPTH));
  assign in_afull = (level_q >= LVL_W'(AFULL));
  assign level    = level_q;

  assign push = in_v  & ~in_b;
  assign pop  = out_v & ~out_b;

  // The storage array is not reset, so an empty queue must not expose it:
  // gating on out_v keeps out_d/out_eos at 0 after reset instead of X.
  assign head    = mem_q[rd_ptr_q];
  assign out_d   = out_v ? head[WIDTH-1:0] : '0;
  assign out_eos = out_v & head[WIDTH];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;  // idle, or push and pop together
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Token storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; stale entries are unreachable because the
  // pointers and level are cleared, which keeps this mappable to plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {in_eos, in_d};
  end

endmodule

// File: tb/tb_tdf_stream_queue.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_tdf_stream_queue
//
// Self-checking bench for tdf_stream_queue. A token queue models the buffer:
// a push is accepted when the model holds fewer than DEPTH tokens, a pop
// happens when it holds any token and out_b is low. Every cycle the DUT
// outputs are compared on the falling edge against the model.
// -----------------------------------------------------------------------------
module tb_tdf_stream_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              clock;
  logic              reset;
  logic [WIDTH-1:0]  in_d;
  logic              in_eos;
  logic              in_v;
  logic              in_b;
  logic              in_afull;
  logic [WIDTH-1:0]  out_d;
  logic              out_eos;
  logic              out_v;
  logic              out_b;
  logic [LVL_W-1:0]  level;

  int checks   = 0;
  int failures = 0;

  // Reference model: front of the queue is the head token {eos, data}.
  logic [WIDTH:0] mq[$];

  tdf_stream_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AFULL (AFULL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_d     (in_d),
    .in_eos   (in_eos),
    .in_v     (in_v),
    .in_b     (in_b),
    .in_afull (in_afull),
    .out_d    (out_d),
    .out_eos  (out_eos),
    .out_v    (out_v),
    .out_b    (out_b),
    .level    (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare all DUT outputs with the model.
  task automatic check_outputs(input string tag);
    int n;
    n = mq.size();
    check({tag, ".level"},    32'(level),    32'(n));
    check({tag, ".out_v"},    32'(out_v),    32'(n != 0));
    check({tag, ".in_b"},     32'(in_b),     32'(n == DEPTH));
    check({tag, ".in_afull"}, 32'(in_afull), 32'(n >= AFULL));
    if (n != 0) begin
      check({tag, ".out_d"},   32'(out_d),   32'(mq[0][WIDTH-1:0]));
      check({tag, ".out_eos"}, 32'(out_eos), 32'(mq[0][WIDTH]));
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, update the model,
  // then compare on the falling edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                       input logic eos, input logic ob, input string tag);
    bit do_push, do_pop;
    in_v   = v;
    in_d   = d;
    in_eos = eos;
    out_b  = ob;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = (mq.size() != 0) && !ob;
    @(posedge clock);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back({eos, d});
    @(negedge clock);
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges; checks the
  // immediate effect before any clock edge occurs.
  task automatic async_reset(input string tag);
    in_v  = 1'b0;
    out_b = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    check({tag, ".rst_level"}, 32'(level),    32'(0));
    check({tag, ".rst_out_v"}, 32'(out_v),    32'(0));
    check({tag, ".rst_in_b"},  32'(in_b),     32'(0));
    check({tag, ".rst_afull"}, 32'(in_afull), 32'(0));
    check({tag, ".rst_out_d"}, 32'(out_d),    32'(0));
    check({tag, ".rst_eos"},   32'(out_eos),  32'(0));
    @(negedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    check_outputs({tag, ".post_rst"});
  endtask

  initial begin
    reset  = 1'b1;
    in_v   = 1'b0;
    in_d   = '0;
    in_eos = 1'b0;
    out_b  = 1'b1;
    #1;
    check("init.level",  32'(level),    32'(0));
    check("init.out_v",  32'(out_v),    32'(0));
    check("init.in_b",   32'(in_b),     32'(0));
    check("init.afull",  32'(in_afull), 32'(0));
    check("init.out_d",  32'(out_d),    32'(0));
    check("init.eos",    32'(out_eos),  32'(0));
    @(negedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);

    // 1: three pushes with the consumer stalled.
    cycle(1'b1, 16'h0011, 1'b0, 1'b1, "t1.p1");
    check("t1.head1", 32'(out_d), 32'h0011);
    cycle(1'b1, 16'h0022, 1'b0, 1'b1, "t1.p2");
    check("t1.afull2", 32'(in_afull), 32'(0));
    cycle(1'b1, 16'h0033, 1'b0, 1'b1, "t1.p3");
    check("t1.head3",  32'(out_d),    32'h0011);
    check("t1.afull3", 32'(in_afull), 32'(1));

    // 2: fill, hold a token against back-pressure, free one slot.
    cycle(1'b1, 16'h0044, 1'b0, 1'b1, "t2.fill");
    check("t2.full", 32'(in_b), 32'(1));
    cycle(1'b1, 16'h0055, 1'b0, 1'b1, "t2.held");
    check("t2.held_level", 32'(level), 32'(4));
    cycle(1'b1, 16'h0055, 1'b0, 1'b0, "t2.pop");
    check("t2.pop_level", 32'(level), 32'(3));
    check("t2.pop_in_b",  32'(in_b),  32'(0));
    check("t2.pop_head",  32'(out_d), 32'h0022);
    cycle(1'b1, 16'h0055, 1'b0, 1'b1, "t2.accept");
    check("t2.refill", 32'(level), 32'(4));

    // 3: streaming 1..20 from an empty queue.
    async_reset("t3");
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b0, 1'b0, "t3.stream");
      check("t3.order", 32'(out_d), 32'(i));
    end
    cycle(1'b0, '0, 1'b0, 1'b0, "t3.drain");

    // 4: EOS flag follows its token.
    cycle(1'b1, 16'h00AA, 1'b1, 1'b1, "t4.aa");
    cycle(1'b1, 16'h00BB, 1'b0, 1'b1, "t4.bb");
    check("t4.eos_aa", 32'(out_eos), 32'(1));
    cycle(1'b0, '0, 1'b0, 1'b0, "t4.pop");
    check("t4.head_bb", 32'(out_d),   32'h00BB);
    check("t4.eos_bb",  32'(out_eos), 32'(0));
    cycle(1'b0, '0, 1'b0, 1'b0, "t4.drain");

    // 5: asynchronous reset with three tokens queued.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, WIDTH'(16'h0060 + i), 1'b0, 1'b1, "t5.fill");
    async_reset("t5");
    cycle(1'b1, 16'h0077, 1'b0, 1'b1, "t5.push");
    check("t5.head", 32'(out_d), 32'h0077);

    // 6: pops on an empty queue must not move the pointers.
    async_reset("t6");
    for (int i = 0; i < 5; i++)
      cycle(1'b0, '0, 1'b0, 1'b0, "t6.idle");
    cycle(1'b1, 16'h0099, 1'b0, 1'b1, "t6.push");
    check("t6.head", 32'(out_d), 32'h0099);
    cycle(1'b0, '0, 1'b0, 1'b0, "t6.pop");

    // Randomized traffic, with occasional mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset("rnd");
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdf_stream_queue.md
Name: tdf_stream_queue

Overview:
- Parameterized elastic stream queue that sits directly upstream of a TDF operator datapath and feeds its input-stream data ports (for example, the `a_d` / `b_d` operands of an adder datapath).
- It decouples the producer from the operator FSM: it buffers tokens, carries an end-of-stream (EOS) flag alongside each token, and presents a valid/back-pressure handshake that the operator FSM uses to select its firing state.
- One instance is placed per operator input stream.

Parameters:
- WIDTH, 16, data bits per token.
- DEPTH, 4, number of token slots. Power of two, at least 2.
- AFULL, 3, occupancy at or above which `in_afull` asserts. Range 1..DEPTH.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_d  in  WIDTH  producer token data.
- in_eos  in  1  producer token is end-of-stream.
- in_v  in  1  producer token valid.
- in_b  out  1  back-pressure to producer (1 = no token accepted this cycle).
- in_afull  out  1  occupancy >= AFULL.
- out_d  out  WIDTH  head token data, to the datapath input.
- out_eos  out  1  head token EOS flag.
- out_v  out  1  head token valid (queue non-empty).
- out_b  in  1  back-pressure from the consumer FSM (1 = head not taken).
- level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry circular buffer of {eos, data}, with write pointer, read pointer and occupancy count. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset (asserted at any time, including mid-stream):
  - pointers = 0, level = 0.
  - out_v = 0, in_b = 0, in_afull = 0.
  - out_d and out_eos are don't-care and must not be X-propagating: drive them to 0.
  - Queued tokens are discarded.
- Push occurs on a clock edge when `in_v & ~in_b`. Pop occurs when `out_v & ~out_b`.
- `in_b` = (level == DEPTH). It is a function of registered state only; there is no combinational path from `out_b` or `in_v`.
- `out_v` = (level != 0). It is a function of registered state only.
- `out_d` / `out_eos` show the entry at the read pointer. They are valid whenever `out_v` = 1 and remain stable while `out_b` holds the token.
- Latency: a token pushed into an empty queue appears at the outputs (`out_v` = 1) on the cycle after the push edge. There is no same-cycle bypass.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- Full queue with a pop this cycle: no push is possible, because `in_b` = 1 that cycle. Next cycle level = DEPTH-1 and `in_b` = 0.
- Empty queue with a push this cycle: no pop (`out_v` = 0). Next cycle level = 1.
- `in_afull` = (level >= AFULL), registered-state based.
- Producer contract:
  - `in_v` with `in_b` = 1 is legal; the token is held by the producer and no state changes.
  - Data must be held until accepted.
- EOS is an ordinary token bit. The queue never drops, merges or generates EOS tokens, and imposes no behaviour after an EOS token.
- Level arithmetic: `level_next = level + push - pop`. This never exceeds DEPTH and never goes below 0 given the rules above.
- All outputs change only on a clock edge or on reset assertion.

Test Plan:
1. Reset, then push 0x0011, 0x0022, 0x0033 on consecutive cycles with `out_b` = 1 -> level 1, 2, 3; `out_d` = 0x0011 throughout; `in_afull` = 1 after the third push (AFULL = 3).
2. Fill to 4 with `out_b` = 1 -> `in_b` = 1 at level 4; a fifth token 0x0055 held with `in_v` = 1 is not accepted. Release `out_b` for one cycle -> 0x0011 popped, next cycle `in_b` = 0 and 0x0055 accepted; level back to 4.
3. Streaming with `in_v` = 1 and `out_b` = 0 for 20 cycles carrying values 1..20 -> output order 1..20, no gaps after the first-token latency of 1 cycle, level constant at 1, pointers wrap at least 4 times.
4. Push 0x00AA with `in_eos` = 1 followed by 0x00BB with `in_eos` = 0 -> `out_eos` = 1 only while 0x00AA is at the head, then 0 for 0x00BB.
5. Assert reset asynchronously between clock edges with level = 3 -> `out_v`, `level` and `in_b` go to 0 immediately. After release, the first new push 0x0077 appears as the head with level 1.
6. Pop on empty: `out_b` = 0, `in_v` = 0 for 5 cycles after reset -> level stays 0, `out_v` = 0, pointers do not move (a subsequent push of 0x0099 is read back correctly).
